// File: rtl/intro_fade_ctrl_pkg.sv
// Shared types and constants for the intro title-screen fade sequencer.
// Holds the sequencer state encoding and the brightness range.
// Imported by the interface, the scaler and the top.
package intro_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2,
    DONE     = 2'd3
  } intro_state_t;

  localparam int                  BRIGHT_W   = 5;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 5'd16;

  // The intro owns the screen in every state except DONE.
  function automatic logic state_active(input intro_state_t s);
    return (s != DONE);
  endfunction

endpackage

// File: rtl/intro_fade_ctrl_if.sv
// Pixel/sync/key inputs and scaled colour/status outputs of the intro fader.
// master drives sync, key and palette pixels; slave is the fader itself.
// No flow control: one pixel per clock, always accepted.
interface intro_fade_ctrl_if;
  import intro_pkg::*;

  logic                vs;
  logic                display_en;
  logic                start_key;
  logic [3:0]          red_in;
  logic [3:0]          green_in;
  logic [3:0]          blue_in;
  logic [3:0]          red;
  logic [3:0]          green;
  logic [3:0]          blue;
  logic [BRIGHT_W-1:0] bright;
  logic                intro_active;
  logic                intro_done;

  modport master (
    output vs, display_en, start_key, red_in, green_in, blue_in,
    input  red, green, blue, bright, intro_active, intro_done
  );

  modport slave (
    input  vs, display_en, start_key, red_in, green_in, blue_in,
    output red, green, blue, bright, intro_active, intro_done
  );

endinterface

// File: rtl/intro_fade_ctrl_rgb_scaler.sv
// Scales one 4-bit colour channel by a 0..16 brightness: out = (in * bright) >> 4.
// Purely combinational; the parent registers the result.
// No backpressure.
module rgb_scaler
  import intro_pkg::*;
(
  input  logic [3:0]          chan_in,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [3:0]          chan_out
);

  // 15 * 16 = 240 is the largest product, so 8 bits never overflow.
  logic [7:0] prod;

  assign prod     = {4'b0000, chan_in} * {3'b000, bright};
  assign chan_out = 4'(prod >> 4);

endmodule

// File: rtl/intro_fade_ctrl.sv
// Intro title sequencer: fades the image in from black, holds until start, fades out, flags done.
// Colour outputs are registered with one cycle of latency; brightness moves only on vsync falling edges.
// No backpressure: consumes one pixel per clock.
module intro_fade_ctrl
  import intro_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_MIN_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  intro_fade_ctrl_if.slave   bus
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = (HOLD_MIN_FRAMES > 0) ? $clog2(HOLD_MIN_FRAMES + 1) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [HOLD_W-1:0] HOLD_MIN  = HOLD_W'(HOLD_MIN_FRAMES);

  intro_state_t        state, state_nxt;
  logic [BRIGHT_W-1:0] bright_q, bright_nxt;
  logic [STEP_W-1:0]   step_cnt, step_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                active_q, done_q;
  logic                active_nxt, done_nxt;
  logic                vs_prev, key_prev;
  logic                tick, press;
  logic [3:0]          red_s, green_s, blue_s;
  logic [3:0]          red_q, green_q, blue_q;

  // A frame tick lands on the vsync falling edge, inside blanking, so brightness never changes mid-frame.
  assign tick  = vs_prev & ~bus.vs;
  assign press = ~key_prev & bus.start_key;

  // Edge detectors; both reset high so a key held through reset is not seen as a press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_prev  <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      vs_prev  <= bus.vs;
      key_prev <= bus.start_key;
    end
  end

  // Sequencer state and brightness counters; status flags update on the same edge as the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= FADE_IN;
      bright_q <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bright_q <= bright_nxt;
      step_cnt <= step_nxt;
      hold_cnt <= hold_nxt;
      active_q <= active_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state: step brightness every FRAMES_PER_STEP ticks while fading, gate start on hold time.
  always_comb begin
    state_nxt  = state;
    bright_nxt = bright_q;
    step_nxt   = step_cnt;
    hold_nxt   = hold_cnt;

    case (state)
      FADE_IN: begin
        if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (bright_q < BRIGHT_MAX) begin
              bright_nxt = bright_q + 5'd1;
            end
            if (bright_q >= BRIGHT_MAX - 5'd1) begin
              state_nxt = HOLD;
              hold_nxt  = '0;
            end
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
      end

      HOLD: begin
        bright_nxt = BRIGHT_MAX;
        // Acceptance looks at the count before this cycle's tick, so a tick cannot unlock a same-cycle press.
        if (press && (hold_cnt >= HOLD_MIN)) begin
          state_nxt = FADE_OUT;
          step_nxt  = '0;
        end else if (tick && (hold_cnt < HOLD_MIN)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      FADE_OUT: begin
        if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (bright_q != '0) begin
              bright_nxt = bright_q - 5'd1;
            end
            if (bright_q <= 5'd1) begin
              state_nxt = DONE;
            end
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
      end

      DONE: begin
        bright_nxt = '0;
      end

      default: begin
        state_nxt  = FADE_IN;
        bright_nxt = '0;
        step_nxt   = '0;
        hold_nxt   = '0;
      end
    endcase

    active_nxt = state_active(state_nxt);
    done_nxt   = (state_nxt == DONE);
  end

  rgb_scaler u_scale_red (
    .chan_in  (bus.red_in),
    .bright   (bright_q),
    .chan_out (red_s)
  );

  rgb_scaler u_scale_green (
    .chan_in  (bus.green_in),
    .bright   (bright_q),
    .chan_out (green_s)
  );

  rgb_scaler u_scale_blue (
    .chan_in  (bus.blue_in),
    .bright   (bright_q),
    .chan_out (blue_s)
  );

  // Registered pixel output; blanking forces black whatever the brightness.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (bus.display_en) begin
      red_q   <= red_s;
      green_q <= green_s;
      blue_q  <= blue_s;
    end else begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end
  end

  assign bus.red          = red_q;
  assign bus.green        = green_q;
  assign bus.blue         = blue_q;
  assign bus.bright       = bright_q;
  assign bus.intro_active = active_q;
  assign bus.intro_done   = done_q;

endmodule
